stump_control_ws: RTL and testbench

Parametrised successor to the Stump control unit: the same FETCH/EXECUTE/MEMORY sequencer and instruction decode, extended with configurable memory wait states and an optional memory-ready handshake. It sits between the instruction register and the Stump datapath/register bank. It drives all datapath selects, ALU function, condition-code enable and memory strobes, and holds them stable while a memory phase is stretched.

---
 rtl/stump_control_ws.sv | 174 +++++++++++++++++
 tb/tb_stump_control_ws.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stump_control_ws.sv
// Stump control unit with configurable FETCH/MEMORY wait states.
// Define STUMP_CTRL_MEM_RDY_EN to also stretch phases until mem_rdy is high.
module stump_control_ws #(
   parameter int WAIT_STATES = 0,
   parameter int WCNT_W      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic [3:0]  cc,
   input  logic        mem_rdy,
   output logic        fetch,
   output logic        execute,
   output logic        memory,
   output logic        ext_op,
   output logic        reg_write,
   output logic [2:0]  dest,
   output logic [2:0]  srcA,
   output logic [2:0]  srcB,
   output logic [1:0]  shift_op,
   output logic        opB_mux_sel,
   output logic [2:0]  alu_func,
   output logic        cc_en,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic        wait_busy
);

   typedef enum logic [1:0] {FETCH, EXECUTE, MEMORY} state_t;

   localparam logic [WCNT_W-1:0] WS = WCNT_W'(WAIT_STATES);
   localparam logic [2:0] OP_MEM = 3'b110;
   localparam logic [2:0] OP_BR  = 3'b111;

   state_t            state, state_nx;
   logic [WCNT_W-1:0] cnt, cnt_nx;
   logic [2:0]        op;
   logic              at_ws, phase_done, cond_true;
   logic              rw_i, cce_i, mr_i, mw_i;
   logic              n, z, v, c;

   assign op    = ir[15:13];
   assign at_ws = (cnt == WS);
   assign {n, z, v, c} = cc;

`ifdef STUMP_CTRL_MEM_RDY_EN
   assign phase_done = at_ws & mem_rdy;
`else
   logic unused_rdy;
   assign unused_rdy = mem_rdy;
   assign phase_done = at_ws;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Counter saturates at WS so a late mem_rdy just holds the phase.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         FETCH: begin
            if (phase_done) begin
               state_nx = EXECUTE;
               cnt_nx   = '0;
            end else if (!at_ws) begin
               cnt_nx = cnt + WCNT_W'(1);
            end
         end
         EXECUTE: begin
            state_nx = (op == OP_MEM) ? MEMORY : FETCH;
            cnt_nx   = '0;
         end
         MEMORY: begin
            if (phase_done) begin
               state_nx = FETCH;
               cnt_nx   = '0;
            end else if (!at_ws) begin
               cnt_nx = cnt + WCNT_W'(1);
            end
         end
         default: begin
            state_nx = FETCH;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      cond_true = 1'b0;
      unique case (ir[11:8])
         4'd0:  cond_true = 1'b1;
         4'd1:  cond_true = 1'b0;
         4'd2:  cond_true = ~c & ~z;
         4'd3:  cond_true = c | z;
         4'd4:  cond_true = ~c;
         4'd5:  cond_true = c;
         4'd6:  cond_true = ~z;
         4'd7:  cond_true = z;
         4'd8:  cond_true = ~v;
         4'd9:  cond_true = v;
         4'd10: cond_true = ~n;
         4'd11: cond_true = n;
         4'd12: cond_true = (n == v);
         4'd13: cond_true = (n != v);
         4'd14: cond_true = ~z & (n == v);
         4'd15: cond_true = z | (n != v);
         default: cond_true = 1'b0;
      endcase
   end

   always_comb begin
      ext_op      = 1'b0;
      rw_i        = 1'b0;
      dest        = ir[10:8];
      srcA        = ir[7:5];
      srcB        = ir[4:2];
      shift_op    = ir[1:0];
      opB_mux_sel = 1'b0;
      alu_func    = 3'b000;
      cce_i       = 1'b0;
      mr_i        = 1'b0;
      mw_i        = 1'b0;
      unique case (state)
         FETCH: mr_i = 1'b1;
         EXECUTE: begin
            if (op == OP_BR) begin
               dest        = 3'd7;
               srcA        = 3'd7;
               opB_mux_sel = 1'b1;
               ext_op      = 1'b1;
               rw_i        = cond_true;
            end else begin
               if (ir[12]) begin
                  opB_mux_sel = 1'b1;
                  shift_op    = 2'b00;
               end
               if (op != OP_MEM) begin
                  alu_func = op;
                  rw_i     = 1'b1;
                  cce_i    = ir[11];
               end
            end
         end
         MEMORY: begin
            if (ir[11]) begin
               mw_i = 1'b1;
               srcB = ir[10:8];
            end else begin
               mr_i = 1'b1;
               rw_i = phase_done;
            end
         end
         default: ;
      endcase
   end

   assign fetch     = (state == FETCH);
   assign execute   = (state == EXECUTE);
   assign memory    = (state == MEMORY);
   assign reg_write = rw_i & ~rst;
   assign cc_en     = cce_i & ~rst;
   assign mem_ren   = mr_i & ~rst;
   assign mem_wen   = mw_i & ~rst;
   assign wait_busy = ~rst & (state != EXECUTE) & ~phase_done;

endmodule

// File: tb/tb_stump_control_ws.sv
// Bench for stump_control_ws: directed checks on WAIT_STATES=0 and 2,
// plus randomized run of the WAIT_STATES=2 instance against a phase model.
module tb_stump_control_ws;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

`ifdef STUMP_CTRL_MEM_RDY_EN
   localparam bit RDY_EN = 1'b1;
`else
   localparam bit RDY_EN = 1'b0;
`endif
   localparam int WS2 = 2;

   logic [15:0] ir0, ir2;
   logic [3:0]  cc0, cc2;
   logic        rdy0, rdy2;
   logic        f0, e0, m0, ext0, rw0, ob0, cce0, mr0, mw0, wb0;
   logic        f2, e2, m2, ext2, rw2, ob2, cce2, mr2, mw2, wb2;
   logic [2:0]  d0, a0, b0, alu0, d2, a2, b2, alu2;
   logic [1:0]  sh0, sh2;

   stump_control_ws #(.WAIT_STATES(0), .WCNT_W(4)) u0 (
      .clk(clk), .rst(rst), .ir(ir0), .cc(cc0), .mem_rdy(rdy0),
      .fetch(f0), .execute(e0), .memory(m0), .ext_op(ext0),
      .reg_write(rw0), .dest(d0), .srcA(a0), .srcB(b0),
      .shift_op(sh0), .opB_mux_sel(ob0), .alu_func(alu0),
      .cc_en(cce0), .mem_ren(mr0), .mem_wen(mw0), .wait_busy(wb0));

   stump_control_ws #(.WAIT_STATES(WS2), .WCNT_W(4)) u2 (
      .clk(clk), .rst(rst), .ir(ir2), .cc(cc2), .mem_rdy(rdy2),
      .fetch(f2), .execute(e2), .memory(m2), .ext_op(ext2),
      .reg_write(rw2), .dest(d2), .srcA(a2), .srcB(b2),
      .shift_op(sh2), .opB_mux_sel(ob2), .alu_func(alu2),
      .cc_en(cce2), .mem_ren(mr2), .mem_wen(mw2), .wait_busy(wb2));

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ARM conditions come in true/inverted pairs; odd codes invert the even one.
   function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] fl);
      bit n, z, v, cy, base;
      n = fl[3]; z = fl[2]; v = fl[1]; cy = fl[0];
      case (cd[3:1])
         3'd0: base = 1'b1;
         3'd1: base = !cy && !z;
         3'd2: base = !cy;
         3'd3: base = !z;
         3'd4: base = !v;
         3'd5: base = !n;
         3'd6: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return cd[0] ? !base : base;
   endfunction

   // Model: phase 0=fetch 1=execute 2=memory, m_n = cycles already spent in phase.
   int m_ph = 0;
   int m_n = 0;

   function automatic bit m_last();
      return (m_n >= WS2) && (!RDY_EN || rdy2);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0;
         m_n = 0;
      end else if (m_ph == 1) begin
         m_ph = (ir2[15:13] == 3'b110) ? 2 : 0;
         m_n = 0;
      end else if (m_last()) begin
         m_ph = (m_ph == 0) ? 1 : 0;
         m_n = 0;
      end else begin
         m_n++;
      end
   end

   always @(negedge clk) begin
      logic [2:0]  op;
      logic [7:0]  ectl;
      logic [15:0] esel, msk, sel;
      bit          last, isld;
      op = ir2[15:13];
      last = m_last();
      ectl = '0;
      esel = '0;
      msk = '0;
      isld = !ir2[11];
      if (rst) begin
         ectl = 8'b1000_0000;
      end else if (m_ph == 0) begin
         ectl = {3'b100, 1'b0, 1'b0, 1'b1, 1'b0, !last};
      end else if (m_ph == 1) begin
         ectl = {3'b010,
                 (op < 6) ? 1'b1 : (op == 6) ? 1'b0 : cond_ok(ir2[11:8], cc2),
                 (op < 6) && ir2[11], 3'b000};
         if (op == 3'b111) begin
            esel = {3'd0, 3'd7, 3'd7, 3'd0, 2'd0, 1'b1, 1'b1};
            msk  = {3'h7, 3'h7, 3'h7, 3'h0, 2'h0, 1'b1, 1'b1};
         end else begin
            esel[15:13] = (op < 6) ? op : 3'd0;
            esel[12:10] = ir2[10:8];
            esel[9:7] = ir2[7:5];
            msk[15:7] = '1;
            if (ir2[12]) begin
               esel[1] = 1'b1;
               msk[3:0] = 4'hf;
            end else begin
               esel[6:4] = ir2[4:2];
               esel[3:2] = ir2[1:0];
               msk[6:1] = '1;
            end
         end
      end else begin
         ectl = {3'b001, isld && last, 1'b0, isld, !isld, !last};
         if (isld) begin
            esel[12:10] = ir2[10:8];
            msk[12:10] = '1;
         end else begin
            esel[6:4] = ir2[10:8];
            msk[6:4] = '1;
         end
      end
      chk("u2_ctl", 16'({f2, e2, m2, rw2, cce2, mr2, mw2, wb2}), 16'(ectl));
      sel = {alu2, d2, a2, b2, sh2, ob2, ext2};
      if (msk != 16'h0) chk("u2_sel", sel & msk, esel);
   end

   logic [2:0] ld_ph [8] = '{3'b100, 3'b100, 3'b100, 3'b010,
                             3'b001, 3'b001, 3'b001, 3'b100};
   logic       ld_rw [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
   logic       ld_mr [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

   initial begin
      ir0 = 16'h0800; cc0 = 4'h0; rdy0 = 1'b1;
      ir2 = 16'h0000; cc2 = 4'h0; rdy2 = 1'b1;
      #1;
      chk("rst_phase", 16'({f0, e0, m0}), 16'(3'b100));
      chk("rst_strobes", 16'({rw0, cce0, mr0, mw0, wb0}), 16'h0);
      tick(); tick();
      rst = 1'b0;
      #1 chk("add_fetch", 16'({f0, e0}), 16'(2'b10));
      tick(); #1;
      chk("add_exec", 16'({e0, rw0, cce0, alu0}), 16'({1'b1, 1'b1, 1'b1, 3'b000}));
      chk("add_opnd", 16'({a0, b0, sh0, ob0}), 16'h0);
      tick(); #1;
      chk("add_refetch", 16'({f0, e0, m0, mw0}), 16'(4'b1000));
      ir0 = 16'hE7FC; cc0 = 4'b0100;
      tick(); #1;
      chk("br_eq_taken", 16'({e0, rw0, d0, ext0}), 16'({1'b1, 1'b1, 3'd7, 1'b1}));
      chk("br_opnd", 16'({a0, ob0, alu0}), 16'({3'd7, 1'b1, 3'd0}));
      tick();
      cc0 = 4'b0000;
      tick(); #1;
      chk("br_eq_not", 16'({e0, rw0}), 16'(2'b10));
      tick();
      rdy0 = 1'b0;
      #1;
`ifdef STUMP_CTRL_MEM_RDY_EN
      for (int i = 0; i < 4; i++) begin
         chk("rdy_stall", 16'({f0, wb0}), 16'(2'b11));
         tick(); #1;
      end
      rdy0 = 1'b1;
      #1 chk("rdy_last", 16'({f0, wb0}), 16'(2'b10));
`else
      chk("rdy_ignored", 16'({f0, wb0}), 16'(2'b10));
`endif
      tick(); #1;
      chk("rdy_exec", 16'(e0), 16'(1'b1));

      rst = 1'b1;
      tick();
      ir2 = 16'hC000; rdy2 = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("ld_phase", 16'({f2, e2, m2}), 16'(ld_ph[i]));
         chk("ld_rw", 16'(rw2), 16'(ld_rw[i]));
         chk("ld_ren", 16'(mr2), 16'(ld_mr[i]));
         tick();
      end
      ir2 = 16'hC800;
      repeat (4) tick();
      #1 chk("st_mem1", 16'({m2, mw2, rw2}), 16'(3'b110));
      tick();
      #1 chk("st_mem2", 16'({m2, mw2, rw2}), 16'(3'b110));
      rst = 1'b1;
      #1 chk("st_abort", 16'({f2, m2, mw2, mr2, rw2}), 16'(5'b10000));
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("post_rst_fetch", 16'(f2), 16'(1'b1));
         tick();
      end
      #1 chk("post_rst_exec", 16'(e2), 16'(1'b1));

      for (int i = 0; i < 3000; i++) begin
         tick();
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 150) == 0) rst = 1'b1;
         if (m_ph == 0) ir2 = 16'($urandom);
         cc2 = 4'($urandom);
         rdy2 = ($urandom_range(0, 3) != 0);
      end
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
